// File: rtl/sens_dly_sequencer_if.sv
// Command/lane bus of the sensor delay sequencer: host command side plus the
// broadcast delay controls that fan out to the pixel lane input cells.
interface sens_dly_sequencer_if #(
    parameter int NUM_LANES = 14,
    parameter int DLY_WIDTH = 8
);
    logic                 cmd_we;
    logic [3:0]           cmd_addr;
    logic [DLY_WIDTH-1:0] cmd_data;
    logic                 cmd_apply;
    logic                 busy;
    logic                 done;
    logic                 wr_err;
    logic [DLY_WIDTH-1:0] dly_data;
    logic [NUM_LANES-1:0] set_idelay;
    logic                 ld_idelay;
    logic [1:0]           quadrant;

    modport master (
        output cmd_we, cmd_addr, cmd_data, cmd_apply,
        input  busy, done, wr_err, dly_data, set_idelay, ld_idelay, quadrant
    );

    modport slave (
        input  cmd_we, cmd_addr, cmd_data, cmd_apply,
        output busy, done, wr_err, dly_data, set_idelay, ld_idelay, quadrant
    );
endinterface

// File: rtl/sens_dly_sequencer.sv
// Sensor port lane delay sequencer: shadows per-lane delays and the quadrant,
// then on apply strobes each changed lane in turn, issues one broadcast load
// with the new quadrant, waits for the delay lines to settle and pulses done.
module sens_dly_sequencer #(
    parameter int NUM_LANES     = 14,
    parameter int DLY_WIDTH     = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 mclk,
    input  logic                 mrst,
    sens_dly_sequencer_if.slave  bus
);
    localparam int         SW        = $clog2(SETTLE_CYCLES + 1);
    localparam logic [3:0] LAST_LANE = 4'(NUM_LANES - 1);
    localparam logic [3:0] QUAD_ADDR = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_LOAD, S_SETTLE} state_t;

    state_t               state_q, state_d;
    logic [3:0]           lane_q, lane_d;
    logic [SW-1:0]        cnt_q, cnt_d;
    logic [DLY_WIDTH-1:0] shadow_q [NUM_LANES];
    logic [DLY_WIDTH-1:0] shadow_d [NUM_LANES];
    logic [1:0]           quad_sh_q, quad_sh_d;
    logic [NUM_LANES-1:0] dirty_q, dirty_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 wr_err_q, wr_err_d;
    logic [DLY_WIDTH-1:0] dly_q, dly_d;
    logic [NUM_LANES-1:0] set_q, set_d;
    logic                 ld_q, ld_d;
    logic [1:0]           quadrant_q, quadrant_d;

    logic                 bad_wr;
    logic                 scan_en;
    logic [3:0]           scan_lane;

    // Next-state logic: shadow writes, error flag, lane walk, load and settle.
    // Lane 0 is handled in the accepting cycle so lane i strobes in the
    // (i+1)-th cycle after the apply, with a same-cycle write already visible.
    always_comb begin
        state_d    = state_q;
        lane_d     = lane_q;
        cnt_d      = cnt_q;
        shadow_d   = shadow_q;
        quad_sh_d  = quad_sh_q;
        dirty_d    = dirty_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        wr_err_d   = wr_err_q;
        dly_d      = dly_q;
        set_d      = '0;
        ld_d       = 1'b0;
        quadrant_d = quadrant_q;
        bad_wr     = 1'b0;
        scan_en    = 1'b0;
        scan_lane  = lane_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_we) begin
                    if (bus.cmd_addr <= LAST_LANE) begin
                        shadow_d[bus.cmd_addr] = bus.cmd_data;
                        dirty_d[bus.cmd_addr]  = 1'b1;
                    end else if (bus.cmd_addr == QUAD_ADDR) begin
                        quad_sh_d = bus.cmd_data[1:0];
                    end else begin
                        bad_wr = 1'b1;
                    end
                end
                if (bus.cmd_apply) begin
                    busy_d    = 1'b1;
                    wr_err_d  = bad_wr;
                    scan_en   = 1'b1;
                    scan_lane = 4'd0;
                end else if (bad_wr) begin
                    wr_err_d = 1'b1;
                end
            end
            S_SCAN: begin
                scan_en = 1'b1;
            end
            S_LOAD: begin
                ld_d       = 1'b1;
                quadrant_d = quad_sh_q;
                cnt_d      = '0;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SW'(SETTLE_CYCLES)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Any command arriving mid-sequence is dropped and flagged.
        if (state_q != S_IDLE && (bus.cmd_we || bus.cmd_apply)) begin
            wr_err_d = 1'b1;
        end

        if (scan_en) begin
            if (dirty_d[scan_lane]) begin
                dly_d              = shadow_d[scan_lane];
                set_d              = NUM_LANES'(1) << scan_lane;
                dirty_d[scan_lane] = 1'b0;
            end
            if (scan_lane == LAST_LANE) begin
                state_d = S_LOAD;
            end else begin
                state_d = S_SCAN;
                lane_d  = scan_lane + 4'd1;
            end
        end
    end

    // State and output registers; reset clears everything including shadows.
    always_ff @(posedge mclk) begin
        if (mrst) begin
            state_q    <= S_IDLE;
            lane_q     <= '0;
            cnt_q      <= '0;
            shadow_q   <= '{default: '0};
            quad_sh_q  <= '0;
            dirty_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_err_q   <= 1'b0;
            dly_q      <= '0;
            set_q      <= '0;
            ld_q       <= 1'b0;
            quadrant_q <= '0;
        end else begin
            state_q    <= state_d;
            lane_q     <= lane_d;
            cnt_q      <= cnt_d;
            shadow_q   <= shadow_d;
            quad_sh_q  <= quad_sh_d;
            dirty_q    <= dirty_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_err_q   <= wr_err_d;
            dly_q      <= dly_d;
            set_q      <= set_d;
            ld_q       <= ld_d;
            quadrant_q <= quadrant_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.wr_err     = wr_err_q;
    assign bus.dly_data   = dly_q;
    assign bus.set_idelay = set_q;
    assign bus.ld_idelay  = ld_q;
    assign bus.quadrant   = quadrant_q;
endmodule
